// File: rtl/uart_ctrl.sv
// ---------------------------------------------------------------------------
// uart_ctrl -- parametrised UART with a runtime baud divisor, programmable
// parity and stop bits, and an RX FIFO that stores error flags with each byte.
//
// Optional build macro: UART_LOOPBACK_EN
//   When defined, adds the 'loopback' input. While loopback=1 the receiver
//   listens to the internal transmit stream and the tx pin is held at 1.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   div_wr, baud_div    load the 16x-oversample tick divisor (0 acts as 1)
//   parity_en/odd,stop2 frame format, captured at each TX/RX frame start
//   din, wr_en          TX byte and write strobe (ignored while tx_busy)
//   tx, tx_busy         serial output and transmitter-occupied flag
//   rx                  asynchronous serial input
//   rdy, rd_en          RX FIFO not-empty flag and pop strobe
//   dout, err_frame,
//   err_parity          FIFO head (first-word-fall-through, zero when empty)
//   overrun, err_clr    sticky dropped-byte flag and its clear
//   rx_count            FIFO occupancy
// ---------------------------------------------------------------------------
module uart_ctrl #(
    parameter int CLK_SPEED   = 50000000,
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 27
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef UART_LOOPBACK_EN
    input  logic                          loopback,
`endif
    input  logic                          div_wr,
    input  logic [15:0]                   baud_div,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          stop2,
    input  logic [DATA_BITS-1:0]          din,
    input  logic                          wr_en,
    output logic                          tx,
    output logic                          tx_busy,
    input  logic                          rx,
    output logic                          rdy,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          dout,
    output logic                          err_frame,
    output logic                          err_parity,
    output logic                          overrun,
    input  logic                          err_clr,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_BITS + 2;
    localparam logic [15:0] RST_DIV = (DEFAULT_DIV < 1) ? 16'd1 : 16'(DEFAULT_DIV);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    // Elaboration-time parameter sanity checks.
    if (CLK_SPEED <= 0) begin : g_bad_clk
        $error("uart_ctrl: CLK_SPEED must be positive");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
        $error("uart_ctrl: DATA_BITS must be 5..8");
    end
    if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
        $error("uart_ctrl: FIFO_DEPTH must be a power of 2, >= 2");
    end

    // -----------------------------------------------------------------------
    // Tick generator: one-cycle tick every div clocks (16 ticks per bit)
    // -----------------------------------------------------------------------
    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tick;

    // '>=' keeps the counter bounded even if it were ever above the divisor.
    assign tick = (cnt_q >= div_q - 16'd1);

    always_comb begin
        div_d = div_q;
        cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
        if (div_wr) begin
            div_d = (baud_div == 16'd0) ? 16'd1 : baud_div;
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= RST_DIV;
            cnt_q <= 16'd0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Transmitter
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    tx_state_e            tx_state_q, tx_state_d;
    logic [4:0]           tx_tcnt_q, tx_tcnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_pen_q, tx_pen_d;
    logic                 tx_pbit_q, tx_pbit_d;
    logic                 tx_stop2_q, tx_stop2_d;
    logic                 tx_q, tx_d;
    logic [4:0]           tx_lim;
    logic                 tx_end;

    // Two stop bits are one 32-tick STOP state rather than two states.
    assign tx_lim = (tx_state_q == TX_STOP && tx_stop2_q) ? 5'd31 : 5'd15;
    assign tx_end = tick && (tx_tcnt_q == tx_lim);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_pen_d   = tx_pen_q;
        tx_pbit_d  = tx_pbit_q;
        tx_stop2_d = tx_stop2_q;

        if (tx_state_q != TX_IDLE && tick) begin
            tx_tcnt_d = tx_tcnt_q + 5'd1;
        end

        unique case (tx_state_q)
            TX_IDLE: begin
                if (wr_en) begin
                    tx_state_d = TX_START;
                    tx_tcnt_d  = 5'd0;
                    tx_sh_d    = din;
                    tx_pen_d   = parity_en;
                    tx_pbit_d  = (^din) ^ parity_odd;
                    tx_stop2_d = stop2;
                end
            end
            TX_START: begin
                if (tx_end) begin
                    tx_state_d = TX_DATA;
                    tx_tcnt_d  = 5'd0;
                    tx_bit_d   = 3'd0;
                end
            end
            TX_DATA: begin
                if (tx_end) begin
                    tx_tcnt_d = 5'd0;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = tx_pen_q ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                        tx_sh_d  = tx_sh_q >> 1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_end) begin
                    tx_state_d = TX_STOP;
                    tx_tcnt_d  = 5'd0;
                end
            end
            TX_STOP: begin
                if (tx_end) begin
                    tx_state_d = TX_IDLE;
                    tx_tcnt_d  = 5'd0;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // Line level derived from the next state so tx is a clean flop output.
        unique case (tx_state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = tx_sh_d[0];
            TX_PARITY: tx_d = tx_pbit_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_tcnt_q  <= 5'd0;
            tx_bit_q   <= 3'd0;
            tx_pen_q   <= 1'b0;
            tx_stop2_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_pen_q   <= tx_pen_d;
            tx_stop2_q <= tx_stop2_d;
            tx_q       <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        tx_sh_q   <= tx_sh_d;
        tx_pbit_q <= tx_pbit_d;
    end

    assign tx_busy = (tx_state_q != TX_IDLE);

    // -----------------------------------------------------------------------
    // Receiver input: synchronizer, optional loopback source
    // -----------------------------------------------------------------------
    logic rx_s1_q, rx_s2_q, rx_prev_q;
    logic rx_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_in;
        end
    end

`ifdef UART_LOOPBACK_EN
    // The internal tx stream is already synchronous, so it skips the synchronizer.
    assign rx_in = loopback ? tx_q : rx_s2_q;
    assign tx    = loopback ? 1'b1 : tx_q;
`else
    assign rx_in = rx_s2_q;
    assign tx    = tx_q;
`endif

    // -----------------------------------------------------------------------
    // Receiver FSM
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_e;

    rx_state_e            rx_state_q, rx_state_d;
    logic [3:0]           rx_tcnt_q, rx_tcnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_pen_q, rx_pen_d;
    logic                 rx_podd_q, rx_podd_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 push;
    logic [EW-1:0]        push_word;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_pen_d   = rx_pen_q;
        rx_podd_d  = rx_podd_q;
        rx_perr_d  = rx_perr_q;
        push       = 1'b0;
        push_word  = {rx_sh_q, ~rx_in, rx_perr_q};

        if (rx_state_q != RX_IDLE && tick) begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
        end

        unique case (rx_state_q)
            RX_IDLE: begin
                // Falling edge, not level: a held-low break cannot retrigger.
                if (!rx_in && rx_prev_q) begin
                    rx_state_d = RX_START;
                    rx_tcnt_d  = 4'd0;
                    rx_pen_d   = parity_en;
                    rx_podd_d  = parity_odd;
                    rx_perr_d  = 1'b0;
                end
            end
            RX_START: begin
                if (tick && rx_tcnt_q == 4'd7) begin
                    rx_tcnt_d = 4'd0;
                    rx_bit_d  = 3'd0;
                    rx_state_d = rx_in ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick && rx_tcnt_q == 4'd15) begin
                    rx_sh_d = {rx_in, rx_sh_q[DATA_BITS-1:1]};
                    if (rx_bit_q == LAST_BIT) begin
                        rx_state_d = rx_pen_q ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (tick && rx_tcnt_q == 4'd15) begin
                    rx_perr_d  = rx_in ^ (^rx_sh_q) ^ rx_podd_q;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                // Push at the centre of the first stop bit; no wait for its end.
                if (tick && rx_tcnt_q == 4'd15) begin
                    push       = 1'b1;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_tcnt_q  <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_pen_q   <= 1'b0;
            rx_podd_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_pen_q   <= rx_pen_d;
            rx_podd_q  <= rx_podd_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    always_ff @(posedge clk) begin
        rx_sh_q <= rx_sh_d;
    end

    // -----------------------------------------------------------------------
    // RX FIFO: entry = {data, frame_err, parity_err}
    // -----------------------------------------------------------------------
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          empty, full, pop, push_ok, ovr_set;
    logic [EW-1:0] head;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop     = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        // Set has priority over clear.
        overrun_d = overrun_q;
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (err_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign head = empty ? '0 : mem_q[rd_ptr_q];

    assign rdy        = !empty;
    assign dout       = head[EW-1:2];
    assign err_frame  = head[1];
    assign err_parity = head[0];
    assign overrun    = overrun_q;
    assign rx_count   = count_q;

endmodule
